// File: rtl/pipe_pulse_pkg.sv
// pipe_pulse_pkg
//   Shared widths, the event record and FSM state encoding for the
//   pipe_pulse receiver. The top level re-declares the event record with its
//   own parameterised widths; pp_evt_t is the default-width form.
package pipe_pulse_pkg;

   localparam int PP_TS_W  = 16;
   localparam int PP_LEN_W = 8;
   localparam int PP_CNT_W = 16;

   typedef struct packed {
      logic [PP_TS_W-1:0]  ts;
      logic [PP_LEN_W-1:0] len;
   } pp_evt_t;

   typedef enum logic {
      PP_IDLE = 1'b0,
      PP_RUN  = 1'b1
   } pp_state_t;

endpackage

// File: rtl/pipe_pulse_receiver_if.sv
// pipe_pulse_receiver_if
//   Valid/ready event stream leaving the pulse receiver.
//   evt_valid : head event present       (master -> slave)
//   evt_ready : consumer takes the head   (slave  -> master)
//   evt_ts    : run start timestamp       (master -> slave)
//   evt_len   : run length in cycles      (master -> slave)
interface pipe_pulse_receiver_if
   import pipe_pulse_pkg::*;
#(
   parameter int TS_W  = PP_TS_W,
   parameter int LEN_W = PP_LEN_W
);
   logic             evt_valid;
   logic             evt_ready;
   logic [TS_W-1:0]  evt_ts;
   logic [LEN_W-1:0] evt_len;

   modport master (output evt_valid, output evt_ts, output evt_len, input evt_ready);
   modport slave  (input evt_valid, input evt_ts, input evt_len, output evt_ready);
endinterface

// File: rtl/pipe_pulse_evt_fifo.sv
// pipe_pulse_evt_fifo
//   Synchronous FIFO of event records, DEPTH entries (power of two, >= 2),
//   built from read/write pointers plus an occupancy count.
//   clk, reset : clock, synchronous active-high reset (control only)
//   push       : request to write push_data; taken when not full or when a
//                pop happens in the same cycle
//   push_data  : record to write
//   pop        : remove the head entry (ignored when empty)
//   head       : current head record, forced to zero while empty
//   full/empty : occupancy flags
module pipe_pulse_evt_fifo
   import pipe_pulse_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = pp_evt_t
)
(
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_en;
   logic          rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop && !empty;
   // When full, a same-cycle pop frees the slot the write lands in: the head
   // is read combinationally before the edge overwrites it.
   assign wr_en = push && (!full || rd_en);

   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pipe_pulse_receiver.sv
// pipe_pulse_receiver
//   Tail sink of the pulse pipeline. Measures each run of consecutive high
//   samples on pipe_in, stamps its first sample with a free-running counter,
//   and queues {ts, len} records for a valid/ready consumer.
//   clk, reset  : clock, synchronous active-high reset
//   pipe_in     : pipeline tail, same clock domain, sampled every edge
//   evt         : event stream (master side): evt_valid/evt_ready/evt_ts/evt_len
//   evt_count   : completed runs since reset, dropped ones included (saturating)
//   drop_count  : runs lost to a full FIFO (saturating)
//   overflow    : sticky, set by the first drop
module pipe_pulse_receiver
   import pipe_pulse_pkg::*;
#(
   parameter int TS_W  = PP_TS_W,
   parameter int LEN_W = PP_LEN_W,
   parameter int DEPTH = 4,
   parameter int CNT_W = PP_CNT_W
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pipe_in,
   pipe_pulse_receiver_if.master evt,
   output logic [CNT_W-1:0]     evt_count,
   output logic [CNT_W-1:0]     drop_count,
   output logic                 overflow
);

   typedef struct packed {
      logic [TS_W-1:0]  ts;
      logic [LEN_W-1:0] len;
   } evt_t;

   pp_state_t        state;
   logic [TS_W-1:0]  ts_cnt;
   logic [TS_W-1:0]  cap_ts;
   logic [LEN_W-1:0] len;

   evt_t push_evt;
   evt_t head_evt;
   logic push;
   logic pop;
   logic drop;
   logic full;
   logic empty;

   function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
      return (&v) ? v : v + LEN_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A run completes on the first low sample seen in RUN; the record is
   // written into the FIFO on that same edge, giving one cycle of latency.
   assign push     = (state == PP_RUN) && !pipe_in;
   assign push_evt = '{ts: cap_ts, len: len};
   assign pop      = evt.evt_valid && evt.evt_ready;
   assign drop     = push && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= PP_IDLE;
         ts_cnt     <= '0;
         evt_count  <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
         case (state)
            PP_IDLE: begin
               if (pipe_in) begin
                  state  <= PP_RUN;
                  cap_ts <= ts_cnt;
                  len    <= LEN_W'(1);
               end
            end
            PP_RUN: begin
               if (pipe_in) begin
                  len <= sat_inc_len(len);
               end else begin
                  state     <= PP_IDLE;
                  evt_count <= sat_inc_cnt(evt_count);
               end
            end
            default: state <= PP_IDLE;
         endcase
         if (drop) begin
            drop_count <= sat_inc_cnt(drop_count);
            overflow   <= 1'b1;
         end
      end
   end

   pipe_pulse_evt_fifo #(
      .DEPTH (DEPTH),
      .T     (evt_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_evt),
      .pop       (pop),
      .head      (head_evt),
      .full      (full),
      .empty     (empty)
   );

   assign evt.evt_valid = !empty;
   assign evt.evt_ts    = head_evt.ts;
   assign evt.evt_len   = head_evt.len;

endmodule

// File: doc/pipe_pulse_receiver.md
Name: pipe_pulse_receiver

Overview:
- Terminal sink for a daisy-chained pulse pipeline. Sits at the tail of the chain and consumes the last stage's pipe_out.
- Detects each run of consecutive high cycles on its input and measures its length. Timestamps the run start against a free-running counter.
- Queues completed events in a small FIFO with a valid/ready output. Keeps event and drop statistics for the debug/CSR path.

Parameters:
- TS_W, 16, width of the free-running timestamp counter and of evt_ts.
- LEN_W, 8, width of the run-length field. Saturating.
- DEPTH, 4, event FIFO depth. Power of two, >= 2.
- CNT_W, 16, width of evt_count and drop_count. Saturating.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pipe_in  in  1  tail of the pulse pipeline; sampled directly, no resynchroniser (same clock domain)
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts the head event
- evt_ts  out  TS_W  start timestamp of the head event
- evt_len  out  LEN_W  high-cycle count of the head event
- evt_count  out  CNT_W  runs completed since reset, including dropped runs
- drop_count  out  CNT_W  runs lost because the FIFO was full
- overflow  out  1  sticky; set on the first drop, cleared only by reset

Behaviour:
- Reset values:
  - All outputs are 0 while reset is high and on the first cycle after release.
  - ts_cnt = 0, FSM in IDLE, FIFO empty.
- Timestamp counter:
  - ts_cnt holds 0 in the first cycle after reset release.
  - Increments by 1 every cycle and wraps modulo 2^TS_W. It is never stalled.
- FSM, two states, IDLE and RUN. pipe_in is sampled at each rising edge.
- IDLE:
  - pipe_in=1 -> go to RUN; cap_ts <= current ts_cnt; len <= 1.
  - Otherwise stay in IDLE.
- RUN, pipe_in=1:
  - Stay in RUN.
  - len <= len+1, saturating at 2^LEN_W-1. The run continues; it is not split.
- RUN, pipe_in=0:
  - The run is complete. Go to IDLE and issue a push of {cap_ts, len}.
  - evt_count increments, saturating.
- A run of one cycle gives len=1. No gap is required between runs: after a RUN->IDLE edge, a high pipe_in in the very next cycle starts a new run.
- Push acceptance:
  - Accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the event is discarded; drop_count increments (saturating) and overflow <= 1.
- Pop: occurs when evt_valid && evt_ready.
  - evt_ts and evt_len are stable while evt_valid=1 and evt_ready=0.
  - evt_ready while evt_valid=0 is ignored.
- Latency:
  - A completing push into an empty FIFO makes evt_valid=1 in the cycle right after the edge that sampled pipe_in=0.
  - That is 1 cycle after the run's final low sample.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy is unchanged; both take effect.
  - Full, push and pop in the same cycle: the push is accepted and there is no drop.
  - Empty, push and pop in the same cycle: impossible, since evt_valid=0.
- Wrap: cap_ts is a raw counter value. Runs spanning the ts_cnt wrap need no special handling.
- Reset mid-run: the partial run is discarded and not counted; FIFO contents are lost.
- Reset while pipe_in=1:
  - The first post-reset sample of 1 starts a new run with ts=0.
  - No edge history is kept across reset.

Decomposition:
- pipe_pulse_pkg:
  - Default widths TS_W, LEN_W, CNT_W.
  - Typedef pp_evt_t = packed struct {ts, len}.
  - FSM state enum {PP_IDLE, PP_RUN}.
- One sub-module, pipe_pulse_evt_fifo:
  - Synchronous FIFO of pp_evt_t, DEPTH entries.
  - Pointer-plus-count implementation; push/pop/full/empty; same-cycle push-on-full-with-pop allowed.
- Top level holds the FSM, ts_cnt and the statistics counters.

Test Plan:
- Single pulse: reset released; pipe_in=1 in cycles 10-12, 0 from cycle 13, evt_ready=1 -> evt_valid=1 for exactly one cycle (cycle 14), evt_ts=10, evt_len=3, evt_count=1.
- Back-to-back runs: pipe_in high in cycle 5, low in 6, high in 7 -> two events {ts=5,len=1} and {ts=7,len=1} in order; evt_count=2.
- Saturation: LEN_W=8; pipe_in high for 300 cycles from cycle 20 -> one event {ts=20,len=255}.
- Overflow/backpressure:
  - Stimulus: DEPTH=4, evt_ready=0; six 1-cycle pulses spaced 3 cycles apart.
  - Response: first 4 events held in order; drop_count=2, overflow=1, evt_count=6.
  - Then raise evt_ready: exactly 4 events drain, then evt_valid=0. overflow stays 1.
- Full with push and pop together: FIFO full, evt_ready=1 in the cycle a run completes -> no drop, occupancy stays 4, the new event appears after the 3 older ones.
- Reset mid-run and wrap:
  - Reset asserted in the 3rd high cycle of a run -> no event, evt_count=0.
  - With TS_W=4, a pulse at ts_cnt=15 lasting 2 cycles -> evt_ts=15, evt_len=2.
